// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field positions and
// the fetch queue entry layout.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int RD_MSB     = 27;
    localparam int RD_LSB     = 22;
    localparam int RS_MSB     = 21;
    localparam int RS_LSB     = 16;
    localparam int RT_MSB     = 15;
    localparam int RT_LSB     = 10;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries with independent push/pop and a
// flush that empties it in one cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Flush drops the write side back onto the read pointer so the head
    // output keeps its last value while the queue is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

    always @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues reads to the
// synchronous instruction memory and feeds decode through a prefetch queue.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_plus1
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [CW-1:0]   credit;
    logic            pop;
    logic            push;
    logic            issue;
    fetch_entry_t    head;
    fetch_entry_t    resp_entry;

    // Credit counts the in-flight read so a returning word always has a slot;
    // a pop frees one in the same cycle, keeping full-rate streaming.
    assign credit     = CW'(DEPTH) - count - CW'(inflight);
    assign id_valid   = (count != '0);
    assign pop        = id_valid && id_ready;
    assign push       = inflight && !redirect_valid;
    assign issue      = !reset && !redirect_valid && ((credit != '0) || pop);
    assign resp_entry = '{pc: inflight_pc, instr: imem_rdata};

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign id_instr    = head.instr;
    assign id_pc       = head.pc;
    assign id_pc_plus1 = head.pc + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd1;
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (resp_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head       (head)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random bench for fetch_queue at DEPTH 4 and 8, with a
// scoreboard of expected PCs checked at every handshake.
module tb_fetch_queue;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        req4, req8, valid4, valid8;
    logic [31:0] addr4, addr8, instr4, instr8, pc4, pc8, p14, p18;
    logic [31:0] rdata4 = '0;
    logic [31:0] rdata8 = '0;

    int          checks = 0;
    int          errors = 0;
    int          pops [2];
    logic [31:0] sbq [2][$];

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u4 (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req4), .imem_addr(addr4), .imem_rdata(rdata4),
        .id_valid(valid4), .id_ready(id_ready), .id_instr(instr4), .id_pc(pc4), .id_pc_plus1(p14)
    );

    fetch_queue #(.DEPTH(8), .RESET_PC(32'h0)) u8 (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req8), .imem_addr(addr8), .imem_rdata(rdata8),
        .id_valid(valid8), .id_ready(id_ready), .id_instr(instr8), .id_pc(pc8), .id_pc_plus1(p18)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00C3;
    endfunction

    // Synchronous instruction memories: data appears the cycle after a request.
    always @(posedge clk) begin
        if (req4) rdata4 <= instr_of(addr4);
        if (req8) rdata8 <= instr_of(addr8);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_stream(input logic [31:0] start, input int n);
        for (int k = 0; k < 2; k++) begin
            sbq[k].delete();
            pops[k] = 0;
            for (int i = 0; i < n; i++) sbq[k].push_back(start + 32'(i));
        end
    endtask

    task automatic pop_check(input int k, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [31:0] plus1);
        logic [31:0] e;
        if (v && id_ready) begin
            pops[k]++;
            check($sformatf("sb%0d_nonempty", k), 32'(sbq[k].size() != 0), 32'd1);
            if (sbq[k].size() != 0) begin
                e = sbq[k].pop_front();
                check($sformatf("sb%0d_pc", k), pc, e);
                check($sformatf("sb%0d_instr", k), instr, instr_of(e));
                check($sformatf("sb%0d_pc_plus1", k), plus1, e + 32'd1);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        pop_check(0, valid4, pc4, instr4, p14);
        pop_check(1, valid8, pc8, instr8, p18);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic restart();
        reset = 1'b1;
        redirect_valid = 1'b0;
        advance();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        pops[0] = 0;
        pops[1] = 0;
        advance();

        check("rst_req", 32'(req4), 0);
        check("rst_addr", addr4, 32'h0);
        check("rst_valid", 32'(valid4), 0);
        check("rst_instr", instr4, 32'h0);
        check("rst_pc", pc4, 32'h0);
        check("rst_pc_plus1", p14, 32'h1);

        // Streaming from reset with decode always ready.
        set_stream(32'h0, 64);
        reset = 1'b0;
        sample();
        check("c0_req", 32'(req4), 1);
        check("c0_addr", addr4, 32'h0);
        check("c0_valid", 32'(valid4), 0);
        advance();
        sample();
        check("c1_valid", 32'(valid4), 0);
        advance();
        for (int c = 2; c < 12; c++) begin
            sample();
            check("stream_valid4", 32'(valid4), 1);
            check("stream_valid8", 32'(valid8), 1);
            advance();
        end
        check("stream_pops", 32'(pops[0]), 10);

        // Backpressure: decode stalled for ten cycles from cycle 0.
        restart();
        set_stream(32'h0, 64);
        id_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (c == 3) check("bp_req_last", 32'(req4), 1);
            if (c >= 4) check("bp_req_off", 32'(req4), 0);
            advance();
        end
        id_ready = 1'b1;
        sample();
        check("bp_head_pc", pc4, 32'h0);
        check("bp_pop_issue", 32'(req4), 1);
        check("bp_pop_addr", addr4, 32'h4);
        advance();
        for (int c = 11; c <= 20; c++) begin
            sample();
            check("bp_drain_valid", 32'(valid4), 1);
            advance();
        end
        check("bp_pops", 32'(pops[0]), 11);

        // Redirect with the queue full and pc 5 at the head.
        restart();
        set_stream(32'h0, 64);
        id_ready = 1'b1;
        for (int c = 0; c < 7; c++) tick();
        id_ready = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        sample();
        check("full_head_pc", pc4, 32'h5);
        check("full_valid", 32'(valid4), 1);
        check("redir_req_off", 32'(req4), 0);
        set_stream(32'h40, 64);
        advance();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        sample();
        check("redir_t1_valid4", 32'(valid4), 0);
        check("redir_t1_valid8", 32'(valid8), 0);
        check("redir_t1_req", 32'(req4), 1);
        check("redir_t1_addr", addr4, 32'h40);
        advance();
        sample();
        check("redir_t2_valid", 32'(valid4), 0);
        advance();
        sample();
        check("redir_t3_valid", 32'(valid4), 1);
        advance();
        tick();
        check("redir_pops", 32'(pops[0]), 2);

        // Redirect in the cycle the response for pc 7 returns.
        restart();
        set_stream(32'h0, 64);
        for (int c = 0; c < 8; c++) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        sample();
        check("drop7_pre_pops", 32'(pops[0]), 7);
        set_stream(32'h100, 64);
        advance();
        redirect_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sample();
            check("drop7_gap_valid", 32'(valid4), 0);
            advance();
        end
        sample();
        check("drop7_target_valid", 32'(valid4), 1);
        advance();
        check("drop7_pops", 32'(pops[0]), 1);

        // Fetch PC wrap from 32'hFFFF_FFFF to 0.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        sample();
        set_stream(32'hFFFF_FFFE, 64);
        advance();
        redirect_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("wrap_pops4", 32'(pops[0]), 6);
        check("wrap_pops8", 32'(pops[1]), 6);

        // Asynchronous reset pulsed mid-cycle with the queue full.
        id_ready = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid4", 32'(valid4), 0);
        check("areset_valid8", 32'(valid8), 0);
        check("areset_req4", 32'(req4), 0);
        check("areset_req8", 32'(req8), 0);
        check("areset_addr", addr4, 32'h0);
        sample();
        advance();
        set_stream(32'h0, 64);
        id_ready = 1'b1;
        reset = 1'b0;
        sample();
        check("areset_c0_req", 32'(req4), 1);
        check("areset_c0_addr", addr4, 32'h0);
        advance();
        tick();
        for (int c = 2; c < 6; c++) tick();
        check("areset_pops", 32'(pops[0]), 4);

        // Random decode backpressure across pointer wrap at both depths.
        restart();
        set_stream(32'h0, 400);
        for (int c = 0; c < 2000 && (pops[0] < 100 || pops[1] < 100); c++) begin
            id_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("rand_pops4", 32'(pops[0] >= 100), 1);
        check("rand_pops8", 32'(pops[1] >= 100), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the pipelined CPU. It owns the fetch PC, issues word-addressed reads to the synchronous instruction memory, and buffers returned instructions in a small prefetch queue. It presents them to the IF/ID buffer through a valid/ready handshake, so decode stalls do not drop fetched words. Branch and jump redirects from the datapath flush the queue and any in-flight read.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- redirect_valid  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  32  target PC, sampled when redirect_valid=1
- imem_req  out  1  read request to instruction memory this cycle
- imem_addr  out  32  read address (registered fetch PC)
- imem_rdata  in  32  instruction returned one cycle after imem_req
- id_valid  out  1  queue head holds a valid instruction
- id_ready  in  1  IF/ID buffer accepts head this cycle
- id_instr  out  32  head instruction
- id_pc  out  32  head PC
- id_pc_plus1  out  32  id_pc + 1 (word addressing)

## Operation
- Reset: fetch_pc=RESET_PC, queue empty, inflight=0. Outputs: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus1=1.
- Issue rule: credit = DEPTH − count − inflight. imem_req=1 when credit>0, or when credit=0 and a pop occurs this cycle, and redirect_valid=0. On issue: fetch_pc += 1 (32-bit wrap), inflight_pc <= fetch_pc, inflight <= 1.
- Response: when inflight=1 and there is no redirect, {inflight_pc, imem_rdata} is pushed at the clock edge. inflight is cleared unless a new issue occurs in the same cycle.
- Pop: occurs when id_valid && id_ready. The head advances, and push and pop can happen in the same cycle. The credit rule guarantees no push when full. Assertion: push while full or pop while empty is an error.
- Redirect (redirect_valid=1):
  - Queue cleared, inflight cleared, and any response returning this cycle is discarded.
  - fetch_pc <= redirect_pc, and imem_req is forced to 0 this cycle.
  - A pop in the same cycle is accepted by the handshake but is irrelevant, because the queue is flushed.
- Priority: reset > redirect > push/pop/issue.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits. Pop and push are performed independently.
- id_instr, id_pc, id_pc_plus1 are driven from the head entry. When id_valid=0 they hold their last value and are don't-care.

## Timing
- Steady state with id_ready=1: one instruction per cycle.
- Sequential fetch: request in cycle t → visible at head with id_valid=1 in cycle t+2. There is no bypass around the queue.
- After reset deassertion: first imem_req in cycle 0 (addr RESET_PC), first id_valid in cycle 2.
- Redirect in cycle t: request to redirect_pc in t+1, id_valid with id_pc=redirect_pc in t+3. id_valid=0 in t+1 and t+2.
- Backpressure: at most DEPTH instructions buffered plus in flight. Once full, a request issues in the same cycle as a pop.
- Reset asserted mid-operation: all state and outputs take reset values immediately, without waiting for a clock edge.

## Structure
- Shared package cpu_pkg holds:
  - instruction width 32, PC width 32
  - opcode field [31:28], rd [27:22], rs [21:16], rt [15:10]
  - default RESET_PC
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}
- One sub-module, fetch_fifo: a synchronous circular buffer of fetch_entry_t with push, pop, flush, count, head. The parent holds fetch_pc, the inflight flag and register, and the issue/credit logic.

## Test plan
- Reset, id_ready=1 always, imem returns addr-based data → id_pc 0,1,2,3… one per cycle from cycle 2, with id_instr matching and id_pc_plus1 = id_pc+1.
- id_ready=0 for 10 cycles from cycle 0 → exactly 4 entries held, imem_req=0 once credit=0. On release, id_pc 0..9 appear with no gaps or duplicates.
- Queue full with head pc 5, redirect_valid at t with redirect_pc=0x40 → id_valid=0 at t+1 and t+2. At t+3, id_pc=0x40, then 0x41; no PC 5–9 is ever presented.
- Redirect in the cycle a response for pc 7 returns, with id_ready=1 → pc 7 is never presented, and the next presented PC is the target.
- Asynchronous reset pulsed mid-cycle while full → id_valid and imem_req drop at once, imem_addr=RESET_PC, and refetch restarts at 0.
- id_ready toggled with a random 50% duty over 100 instructions, DEPTH=4 and DEPTH=8 → in-order stream with no loss across pointer wrap. fetch_pc=32'hFFFF_FFFF wraps to 0.
